// File: rtl/gg_accum_pkg.sv
// gg_accum_pkg: shared FSM state, widths and counter sizing for the frame accumulator
package gg_accum_pkg;
  typedef enum logic {ACCUM, DONE} state_t;
  localparam int SUM_ACC_W = 17;
  localparam int FRAME_ID_W = 8;
  function automatic int cnt_width(input int frame_len);
    return (frame_len <= 2) ? 1 : $clog2(frame_len);
  endfunction
endpackage

// File: rtl/gg_sat_add.sv
// gg_sat_add: unsigned saturating adder, ACC_W + IN_W -> ACC_W, o_sat set when clamped
// ports: i_a accumulator, i_b addend, o_sum clamped result, o_sat clamp flag
module gg_sat_add #(
  parameter int ACC_W = 24,
  parameter int IN_W = 16
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_sat
);
  logic [ACC_W:0] w_full;
  assign w_full = {1'b0, i_a} + {{(ACC_W + 1 - IN_W){1'b0}}, i_b};
  assign o_sat = w_full[ACC_W];
  assign o_sum = o_sat ? '1 : w_full[ACC_W-1:0];
endmodule

// File: rtl/gg_prod_accum.sv
// gg_prod_accum: accumulates FRAME_LEN sum/prod samples into a one-deep valid/ready result register
// ports: clk/reset (async, high), clr (sync frame clear), in_valid/in_ready/sum/prod sample input,
//        out_valid/out_ready handshake with out_acc_prod, out_acc_sum, out_sat, out_frame_id
module gg_prod_accum
  import gg_accum_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8:0]            sum,
  input  logic [15:0]           prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_acc_prod,
  output logic [SUM_ACC_W-1:0]  out_acc_sum,
  output logic                  out_sat,
  output logic [FRAME_ID_W-1:0] out_frame_id
);
  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  state_t r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc_prod, w_prod_nxt, w_ld_prod;
  logic [SUM_ACC_W-1:0] r_acc_sum, w_sum_nxt, w_ld_sum;
  logic r_sat, w_prod_sat, w_ld_sat;
  logic [CNT_W-1:0] r_cnt;
  logic [FRAME_ID_W-1:0] r_frame_id;
  logic w_accept, w_last, w_free, w_load, w_done;
  gg_sat_add #(.ACC_W(ACC_W), .IN_W(16)) u_sat_add (
    .i_a  (r_acc_prod),
    .i_b  (prod),
    .o_sum(w_prod_nxt),
    .o_sat(w_prod_sat)
  );
  assign w_done = (r_state == DONE);
  assign in_ready = !w_done;
  assign w_accept = in_valid && in_ready && !clr;
  assign w_last = w_accept && (r_cnt == LAST);
  assign w_free = !out_valid || out_ready;
  assign w_load = !clr && w_free && (w_last || w_done);
  assign w_sum_nxt = r_acc_sum + SUM_ACC_W'(sum);
  // in DONE the accumulator already holds the completed frame; otherwise fold in the last sample
  assign w_ld_prod = w_done ? r_acc_prod : w_prod_nxt;
  assign w_ld_sum = w_done ? r_acc_sum : w_sum_nxt;
  assign w_ld_sat = w_done ? r_sat : (r_sat | w_prod_sat);
  always_comb begin
    w_state_nxt = clr ? ACCUM : w_done ? (w_free ? ACCUM : DONE) : (w_last && !w_free) ? DONE : ACCUM;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      r_acc_prod <= '0;
      r_acc_sum <= '0;
      r_sat <= 1'b0;
      r_cnt <= '0;
      r_frame_id <= '0;
      out_valid <= 1'b0;
      out_acc_prod <= '0;
      out_acc_sum <= '0;
      out_sat <= 1'b0;
      out_frame_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clr || w_load) begin
        r_acc_prod <= '0;
        r_acc_sum <= '0;
        r_sat <= 1'b0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc_prod <= w_prod_nxt;
        r_acc_sum <= w_sum_nxt;
        r_sat <= r_sat | w_prod_sat;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_load) begin
        out_valid <= 1'b1;
        out_acc_prod <= w_ld_prod;
        out_acc_sum <= w_ld_sum;
        out_sat <= w_ld_sat;
        out_frame_id <= r_frame_id;
        r_frame_id <= r_frame_id + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/gg_prod_accum.md
# gg_prod_accum

Frame accumulator placed directly downstream of gg_my_IP. It consumes the registered sum (9-bit) and prod (16-bit) outputs, one sample per accepted handshake, and accumulates FRAME_LEN samples into a saturating product total and an exact sum total. Each completed frame goes into a one-deep output register with a valid/ready handshake. Upstream is stalled only while a finished frame cannot be handed off.

## Interface
- FRAME_LEN, 16: samples per frame; legal range 1..256.
- ACC_W, 24: product accumulator width; legal range 16..32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- clr  in  1  synchronous clear of the frame in progress.
- in_valid  in  1  sum/prod carry a sample.
- in_ready  out  1  block can accept a sample.
- sum  in  9  gg_my_IP sum output.
- prod  in  16  gg_my_IP prod output.
- out_valid  out  1  result register holds an unread frame.
- out_ready  in  1  consumer takes result.
- out_acc_prod  out  ACC_W  saturating sum of prod over the frame.
- out_acc_sum  out  17  exact sum of sum over the frame.
- out_sat  out  1  product accumulator saturated in this frame.
- out_frame_id  out  8  frame index; wraps 255->0.

## Operation
- Accept a sample when in_valid && in_ready. Transfer a result when out_valid && out_ready.
- FSM states:
  - ACCUM (reset state): in_ready=1.
  - DONE: frame complete, waiting for the output register; in_ready=0.
- Per accepted sample:
  - acc_sum += sum (17 bits; cannot overflow for FRAME_LEN≤256).
  - acc_prod += prod, clamped at 2^ACC_W-1. Any clamp sets the frame's sticky sat flag.
  - cnt increments.
- Accepting sample number FRAME_LEN (cnt == FRAME_LEN-1):
  - If the output register is free this cycle (!out_valid || out_ready): load totals (including this sample), sat and frame_id into the output register; set out_valid. Clear acc, cnt and sat; increment frame_id. Stay in ACCUM.
  - Otherwise: keep the totals in the accumulator and go to DONE.
- DONE: when the output register is free, load it exactly as above and return to ACCUM.
- Output register holds its contents while out_valid && !out_ready. out_valid drops after a transfer unless a new load happens on the same edge (back-to-back frames).
- clr (sync): clears acc, cnt and sat, and sets state to ACCUM.
  - A sample presented in the same cycle is dropped.
  - clr in DONE discards the pending frame; frame_id does not increment.
  - Output register and out_valid are unaffected.
- FRAME_LEN=1: every accepted sample produces a frame.

## Timing
- Reset values: out_valid 0, out_acc_prod 0, out_acc_sum 0, out_sat 0, out_frame_id 0, in_ready 1, state ACCUM, cnt 0.
- Latency: last sample accepted at edge N → out_valid high and data valid immediately after edge N.
- in_ready is a combinational decode of state only, with no path from out_ready. It drops the cycle after entering DONE.
- DONE→ACCUM happens on the edge where the register frees; in_ready returns high the following cycle.
- Reset asserted mid-frame or mid-handshake clears immediately (async). A held result is lost.

## Structure
- Shared package gg_accum_pkg:
  - FSM state typedef (ACCUM, DONE).
  - SUM_ACC_W=17.
  - FRAME_ID_W=8.
  - Function computing cnt width from FRAME_LEN.
- Sub-module gg_sat_add: parameterised unsigned saturating adder (ACC_W + 16 → ACC_W, plus sat flag), used for acc_prod.
- All registers are in the top module under one always block with async reset.

## Test plan
- FRAME_LEN=4, out_ready=1, stream a=b=1..4 (sum 2,4,6,8; prod 1,4,9,16) → one cycle after the 4th accept: out_acc_sum=20, out_acc_prod=30, out_sat=0, out_frame_id=0; in_ready never drops.
- FRAME_LEN=2, out_ready=0, continuous valid samples → frame 0 in register, frame 1 completes → DONE, in_ready=0. Raise out_ready one cycle → frame 0 transferred, frame 1 loaded (out_frame_id=1), in_ready=1 next cycle.
- ACC_W=16, FRAME_LEN=2, prod=65025 twice → out_acc_prod=65535, out_sat=1. Next frame prod=1 twice → 2, out_sat=0.
- FRAME_LEN=4: accept 2 samples, assert clr together with a 3rd sample → that sample dropped. Next 4 samples of sum=10, prod=100 → out_acc_sum=40, out_acc_prod=400.
- FRAME_LEN=1, out_ready=1, 257 samples → out_frame_id runs 0..255 then 0; out_valid high continuously.
- Assert reset mid-frame with out_valid=1 → all outputs 0 and in_ready=1 immediately; the next full frame reports out_frame_id=0.
